// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared geometry helpers for triangular pack/expand blocks
package matrix_pkg;

    localparam int MAX_SIZE  = 256;
    localparam int MAX_IDX_W = 8;

    typedef logic [MAX_IDX_W-1:0] tri_idx_t;

    function automatic int tri_count(input int n);
        return n * (n + 1) / 2;
    endfunction

    // Index width never collapses to zero bits, even for the smallest matrix.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tri_pos_counter.sv
// rtl/tri_pos_counter.sv - row/col walker over an N x N matrix with upper-triangle phase flag
module tri_pos_counter
    import matrix_pkg::*;
#(
    parameter int SIZE = 4
)(
    input  logic clk,
    input  logic rst,
    input  logic i_adv,
    output logic o_pass,
    output logic o_frame_end
);

    localparam int             W    = idx_width(SIZE);
    localparam logic [W-1:0]   LAST = W'(SIZE - 1);

    logic [W-1:0] r_row;
    logic [W-1:0] r_col;
    logic         w_col_last;
    logic         w_row_last;

    assign w_col_last  = (r_col == LAST);
    assign w_row_last  = (r_row == LAST);
    assign o_pass      = (r_col >= r_row);
    assign o_frame_end = w_row_last && w_col_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_adv) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/upper_triangular_expand.sv
// rtl/upper_triangular_expand.sv - packed upper triangle to dense matrix stream; optional out_tlast via UPPER_TRIANGULAR_EXPAND_TLAST_EN
module upper_triangular_expand
    import matrix_pkg::*;
#(
    parameter int SIZE       = 4,
    parameter int DATA_WIDTH = 32
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_tdata,
    input  logic                  in_tvalid,
    output logic                  in_tready,
    output logic [DATA_WIDTH-1:0] out_tdata,
    output logic                  out_tvalid,
    input  logic                  out_tready
`ifdef UPPER_TRIANGULAR_EXPAND_TLAST_EN
    ,
    output logic                  out_tlast
`endif
);

    logic                  w_pass;
    logic                  w_frame_end;
    logic                  w_load;
    logic                  w_pass_step;
    logic                  w_fill_step;
    logic                  w_adv;
    logic [DATA_WIDTH-1:0] r_out_tdata;
    logic                  r_out_tvalid;

    // Below-diagonal positions are generated locally, so input is held off there.
    assign w_load      = !r_out_tvalid || out_tready;
    assign in_tready   = w_load && w_pass;
    assign w_pass_step = in_tvalid && in_tready;
    assign w_fill_step = w_load && !w_pass;
    assign w_adv       = w_pass_step || w_fill_step;

    tri_pos_counter #(
        .SIZE        (SIZE)
    ) u_pos (
        .clk         (clk),
        .rst         (rst),
        .i_adv       (w_adv),
        .o_pass      (w_pass),
        .o_frame_end (w_frame_end)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_tdata  <= '0;
            r_out_tvalid <= 1'b0;
        end else if (w_load) begin
            if (w_pass_step) begin
                r_out_tdata  <= in_tdata;
                r_out_tvalid <= 1'b1;
            end else if (w_fill_step) begin
                r_out_tdata  <= '0;
                r_out_tvalid <= 1'b1;
            end else begin
                r_out_tvalid <= 1'b0;
            end
        end
    end

    assign out_tdata  = r_out_tdata;
    assign out_tvalid = r_out_tvalid;

`ifdef UPPER_TRIANGULAR_EXPAND_TLAST_EN
    logic r_out_tlast;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_tlast <= 1'b0;
        end else if (w_adv) begin
            r_out_tlast <= w_frame_end;
        end else if (w_load) begin
            r_out_tlast <= 1'b0;
        end
    end

    assign out_tlast = r_out_tlast;
`else
    logic w_unused_frame_end;
    assign w_unused_frame_end = w_frame_end;
`endif

endmodule

// File: tb/tb_upper_triangular_expand.sv
// tb/tb_upper_triangular_expand.sv - self-checking bench for upper_triangular_expand
module tb_upper_triangular_expand;
    import matrix_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] in_tdata = '0;
    logic          in_tvalid = 1'b0;
    logic          in_tready;
    logic [DW-1:0] out_tdata;
    logic          out_tvalid;
    logic          out_tready = 1'b1;
`ifdef UPPER_TRIANGULAR_EXPAND_TLAST_EN
    logic          out_tlast;
`endif

    int errors = 0;
    int checks = 0;

    logic          g_acc, g_ofire, g_ov, g_ir;
    logic [DW-1:0] g_od;
    logic [DW-1:0] g_in[$];
    logic [DW-1:0] g_exp[$];
    logic [DW-1:0] g_out[$];
    int            g_ocyc[$];
    int            g_icyc[$];

    upper_triangular_expand #(
        .SIZE       (N),
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_tdata   (in_tdata),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready)
`ifdef UPPER_TRIANGULAR_EXPAND_TLAST_EN
        ,
        .out_tlast  (out_tlast)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Dense matrix reference: walk every position, upper triangle consumes inputs.
    function automatic void build_expected(input int frames);
        int k;
        k = 0;
        g_exp.delete();
        for (int f = 0; f < frames; f++)
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    if (c >= r) begin
                        g_exp.push_back(g_in[k]);
                        k++;
                    end else begin
                        g_exp.push_back('0);
                    end
    endfunction

    task automatic step(input logic v, input logic [DW-1:0] d, input logic rdy);
        @(negedge clk);
        in_tvalid  = v;
        in_tdata   = d;
        out_tready = rdy;
        #1;
        g_acc   = in_tvalid && in_tready;
        g_ofire = out_tvalid && out_tready;
        g_ov    = out_tvalid;
        g_od    = out_tdata;
        g_ir    = in_tready;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        in_tvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_stream(input int vpct, input int rpct, input int max_cyc);
        int k;
        int cyc;
        int pos;
        k = 0;
        cyc = 0;
        g_out.delete();
        g_ocyc.delete();
        g_icyc.delete();
        while (g_out.size() < g_exp.size() && cyc < max_cyc) begin
            logic v;
            logic r;
            v = (k < g_in.size()) && ($urandom_range(99) < vpct);
            r = ($urandom_range(99) < rpct);
            step(v, (k < g_in.size()) ? g_in[k] : DW'($urandom), r);
            pos = (g_out.size() + (g_ov ? 1 : 0)) % (N * N);
            if (pos / N > pos % N) begin
                checks++;
                if (g_ir !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_ready: in_tready=%0b at position %0d, required 0", g_ir, pos);
                end
            end
            if (g_acc) begin
                k++;
                g_icyc.push_back(cyc);
            end
            if (g_ofire) begin
                g_out.push_back(g_od);
                g_ocyc.push_back(cyc);
            end
            cyc++;
        end
        in_tvalid = 1'b0;
    endtask

    task automatic compare_stream(input string name);
        checks++;
        if (g_out.size() !== g_exp.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d beats, required %0d", name, g_out.size(), g_exp.size());
        end
        for (int i = 0; i < g_exp.size() && i < g_out.size(); i++) begin
            checks++;
            if (g_out[i] !== g_exp[i]) begin
                errors++;
                $display("FAIL %s_beat%0d: got %0d, required %0d", name, i, g_out[i], g_exp[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_tvalid = 1'b0;
        out_tready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (out_tvalid !== 1'b0 || out_tdata !== '0) begin
            errors++;
            $display("FAIL reset_out: tvalid=%0b tdata=%0d, required 0/0", out_tvalid, out_tdata);
        end
        rst = 1'b1;
        step(1'b0, '0, 1'b1);
        checks++;
        if (g_ir !== 1'b1 || g_ov !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: in_tready=%0b out_tvalid=%0b, required 1/0", g_ir, g_ov);
        end
    endtask

    task automatic test_basic_frame();
        do_reset();
        g_in.delete();
        for (int i = 1; i <= tri_count(N); i++) g_in.push_back(DW'(i));
        build_expected(1);
        run_stream(100, 100, 100);
        compare_stream("basic");
        if (g_ocyc.size() == N * N && g_icyc.size() > 0) begin
            checks++;
            if (g_ocyc[0] !== g_icyc[0] + 1) begin
                errors++;
                $display("FAIL basic_latency: first beat cycle %0d, required %0d", g_ocyc[0], g_icyc[0] + 1);
            end
            checks++;
            if (g_ocyc[N*N-1] - g_ocyc[0] !== N * N - 1) begin
                errors++;
                $display("FAIL basic_span: span %0d cycles, required %0d", g_ocyc[N*N-1] - g_ocyc[0], N * N - 1);
            end
        end
    endtask

    task automatic test_fill_independence();
        do_reset();
        for (int i = 1; i <= N; i++) step(1'b1, DW'(i), 1'b1);
        step(1'b0, '0, 1'b1);
        checks++;
        if (g_ir !== 1'b0 || g_ov !== 1'b1 || g_od !== DW'(N)) begin
            errors++;
            $display("FAIL fill_cycle: in_tready=%0b tvalid=%0b tdata=%0d, required 0/1/%0d", g_ir, g_ov, g_od, N);
        end
        step(1'b0, '0, 1'b1);
        checks++;
        if (g_ov !== 1'b1 || g_od !== '0) begin
            errors++;
            $display("FAIL fill_zero: tvalid=%0b tdata=%0d, required 1/0", g_ov, g_od);
        end
        step(1'b0, '0, 1'b1);
        checks++;
        if (g_ov !== 1'b0 || g_ir !== 1'b1) begin
            errors++;
            $display("FAIL fill_idle: tvalid=%0b in_tready=%0b, required 0/1", g_ov, g_ir);
        end
        step(1'b1, 32'd5, 1'b1);
        step(1'b0, '0, 1'b1);
        checks++;
        if (g_ov !== 1'b1 || g_od !== 32'd5) begin
            errors++;
            $display("FAIL fill_resume: tvalid=%0b tdata=%0d, required 1/5", g_ov, g_od);
        end
    endtask

    task automatic test_backpressure();
        int k;
        int cyc;
        int mark;
        do_reset();
        g_in.delete();
        for (int i = 1; i <= tri_count(N); i++) g_in.push_back(DW'(i));
        build_expected(1);
        g_out.delete();
        k = 0;
        cyc = 0;
        while (cyc < 60) begin
            step(k < g_in.size(), (k < g_in.size()) ? g_in[k] : '0, 1'b1);
            if (g_acc) k++;
            if (g_ofire) g_out.push_back(g_od);
            cyc++;
            if (g_ofire && g_od == 32'd5) break;
        end
        mark = g_out.size();
        for (int s = 0; s < 3; s++) begin
            step(k < g_in.size(), (k < g_in.size()) ? g_in[k] : '0, 1'b0);
            if (g_acc) k++;
            checks++;
            if (g_ov !== 1'b1 || g_od !== 32'd6 || g_ir !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall%0d: tvalid=%0b tdata=%0d in_tready=%0b, required 1/6/0", s, g_ov, g_od, g_ir);
            end
        end
        while (g_out.size() < g_exp.size() && cyc < 120) begin
            step(k < g_in.size(), (k < g_in.size()) ? g_in[k] : '0, 1'b1);
            if (g_acc) k++;
            if (g_ofire) g_out.push_back(g_od);
            cyc++;
        end
        in_tvalid = 1'b0;
        checks++;
        if (g_out.size() < mark + 2 || g_out[mark+1] !== 32'd7) begin
            errors++;
            $display("FAIL bp_resume: beat after 6 is %0d, required 7", (g_out.size() > mark + 1) ? g_out[mark+1] : '0);
        end
        compare_stream("bp");
    endtask

    task automatic test_back_to_back();
        do_reset();
        g_in.delete();
        for (int i = 1; i <= 2 * tri_count(N); i++) g_in.push_back(DW'(i));
        build_expected(2);
        run_stream(100, 100, 200);
        compare_stream("b2b");
        if (g_ocyc.size() == 2 * N * N) begin
            checks++;
            if (g_ocyc[N*N] !== g_ocyc[N*N-1] + 1) begin
                errors++;
                $display("FAIL b2b_bubble: frame2 starts cycle %0d, required %0d", g_ocyc[N*N], g_ocyc[N*N-1] + 1);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int acc;
        int cyc;
        do_reset();
        acc = 0;
        cyc = 0;
        while (acc < 5 && cyc < 40) begin
            step(1'b1, DW'(acc + 1), 1'b1);
            if (g_acc) acc++;
            cyc++;
        end
        @(posedge clk);
        #2;
        checks++;
        if (out_tvalid !== 1'b1 || out_tdata !== 32'd5) begin
            errors++;
            $display("FAIL mid_pre: tvalid=%0b tdata=%0d, required 1/5", out_tvalid, out_tdata);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (out_tvalid !== 1'b0 || out_tdata !== '0) begin
            errors++;
            $display("FAIL mid_async: tvalid=%0b tdata=%0d, required 0/0", out_tvalid, out_tdata);
        end
        in_tvalid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        g_in.delete();
        for (int i = 0; i < tri_count(N); i++) g_in.push_back(DW'(42 + i));
        build_expected(1);
        run_stream(100, 100, 100);
        checks++;
        if (g_out.size() == 0 || g_out[0] !== 32'd42) begin
            errors++;
            $display("FAIL mid_first: first beat %0d, required 42", (g_out.size() > 0) ? g_out[0] : '0);
        end
        compare_stream("mid");
    endtask

    task automatic test_random();
        do_reset();
        g_in.delete();
        for (int i = 0; i < 3 * tri_count(N); i++) g_in.push_back(DW'($urandom));
        build_expected(3);
        run_stream(60, 60, 2000);
        compare_stream("rand_a");
        g_in.delete();
        for (int i = 0; i < 2 * tri_count(N); i++) g_in.push_back(DW'($urandom));
        build_expected(2);
        run_stream(90, 40, 2000);
        compare_stream("rand_b");
    endtask

`ifdef UPPER_TRIANGULAR_EXPAND_TLAST_EN
    task automatic test_tlast();
        int k;
        int cyc;
        int beats;
        int stalls;
        logic rdy;
        do_reset();
        k = 0;
        cyc = 0;
        beats = 0;
        stalls = 2;
        while (beats < N * N && cyc < 100) begin
            @(negedge clk);
            rdy = !(out_tvalid && out_tdata == DW'(tri_count(N)) && stalls > 0);
            in_tvalid  = (k < tri_count(N));
            in_tdata   = DW'(k + 1);
            out_tready = rdy;
            #1;
            if (!rdy) begin
                stalls--;
                checks++;
                if (out_tlast !== 1'b1) begin
                    errors++;
                    $display("FAIL tlast_stall: out_tlast=%0b, required 1", out_tlast);
                end
            end
            if (in_tvalid && in_tready) k++;
            if (out_tvalid && out_tready) begin
                checks++;
                if (out_tlast !== (beats == N * N - 1)) begin
                    errors++;
                    $display("FAIL tlast_beat%0d: out_tlast=%0b, required %0b", beats, out_tlast, beats == N * N - 1);
                end
                beats++;
            end
            cyc++;
        end
        in_tvalid = 1'b0;
        checks++;
        if (beats !== N * N) begin
            errors++;
            $display("FAIL tlast_count: got %0d beats, required %0d", beats, N * N);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_fill_independence();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
`ifdef UPPER_TRIANGULAR_EXPAND_TLAST_EN
        test_tlast();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
